// File: rtl/amoled_row_waveform_seq_pkg.sv
// Shared phase encoding, config select codes and reset-default durations for the row waveform sequencer.
// No logic; imported by the interface, timer and top.
package amoled_wave_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_PROG  = 3'd2,
    PH_EMIT  = 3'd3,
    PH_COMP2 = 3'd4,
    PH_TAIL  = 3'd5
  } phase_e;

  localparam logic [2:0] SEL_INIT  = 3'd0;
  localparam logic [2:0] SEL_PROG  = 3'd1;
  localparam logic [2:0] SEL_EMIT  = 3'd2;
  localparam logic [2:0] SEL_COMP2 = 3'd3;
  localparam logic [2:0] SEL_TAIL  = 3'd4;
  localparam int         NUM_DUR   = 5;

  localparam int DEF_INIT  = 2000;
  localparam int DEF_PROG  = 3000;
  localparam int DEF_EMIT  = 50000;
  localparam int DEF_COMP2 = 3000;
  localparam int DEF_TAIL  = 2000;

  // Maps a phase to the duration slot it is timed by; IDLE has no slot and returns INIT's.
  function automatic logic [2:0] phase_sel(phase_e p);
    case (p)
      PH_PROG:  return SEL_PROG;
      PH_EMIT:  return SEL_EMIT;
      PH_COMP2: return SEL_COMP2;
      PH_TAIL:  return SEL_TAIL;
      default:  return SEL_INIT;
    endcase
  endfunction

endpackage

// File: rtl/amoled_row_waveform_seq_if.sv
// Control/config inputs and per-row drive outputs between the timing controller and the sequencer.
// master = timing controller side, slave = sequencer side.
interface amoled_row_waveform_seq_if #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 17
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             enable;
  logic             continuous;
  logic             frame_start;
  logic             cfg_wr;
  logic [2:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic [ROWS-1:0]  vinit;
  logic [ROWS-1:0]  vcomp;
  logic [ROWS-1:0]  vscan;
  logic [ROWS-1:0]  vem1;
  logic [ROWS-1:0]  vem2;
  logic             busy;
  logic [RW-1:0]    row_idx;
  logic             frame_done;

  modport master (
    output enable, continuous, frame_start, cfg_wr, cfg_sel, cfg_data,
    input  vinit, vcomp, vscan, vem1, vem2, busy, row_idx, frame_done
  );

  modport slave (
    input  enable, continuous, frame_start, cfg_wr, cfg_sel, cfg_data,
    output vinit, vcomp, vscan, vem1, vem2, busy, row_idx, frame_done
  );

endinterface

// File: rtl/amoled_row_waveform_seq_timer.sv
// Phase down-counter: load sets the count (0 treated as 1), expire is high while count==1.
// Expire is combinational from the count register; no backpressure.
module amoled_phase_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (count > CNT_W'(1)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/amoled_row_waveform_seq.sv
// Multi-row AMOLED drive sequencer: per-row INIT/PROG, then global EMIT/COMP2/TAIL, runtime durations.
// Drives registered from next state (change on the phase edge); frame_start ignored while busy or disabled.
module amoled_row_waveform_seq
  import amoled_wave_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int CNT_W   = 17,
  parameter int D_INIT  = DEF_INIT,
  parameter int D_PROG  = DEF_PROG,
  parameter int D_EMIT  = DEF_EMIT,
  parameter int D_COMP2 = DEF_COMP2,
  parameter int D_TAIL  = DEF_TAIL
) (
  input logic                      clk,
  input logic                      reset,
  amoled_row_waveform_seq_if.slave bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  typedef logic [CNT_W-1:0] dur_t;
  localparam dur_t DEFS [NUM_DUR] = '{dur_t'(D_INIT), dur_t'(D_PROG), dur_t'(D_EMIT),
                                      dur_t'(D_COMP2), dur_t'(D_TAIL)};

  dur_t            shadow [NUM_DUR];
  dur_t            active [NUM_DUR];
  phase_e          state, state_nxt;
  logic [RW-1:0]   row, row_nxt;
  logic            start_evt, cont_q, expire, tmr_load;
  dur_t            tmr_val;
  logic [ROWS-1:0] row_oh, vinit_d, vcomp_d, vscan_d, vem1_d, vem2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= DEFS;
      active <= DEFS;
      cont_q <= 1'b0;
    end else begin
      if (bus.cfg_wr && (bus.cfg_sel < 3'(NUM_DUR))) shadow[bus.cfg_sel] <= bus.cfg_data;
      // Copy happens before this edge's cfg_wr lands, so a same-cycle write waits for the next frame.
      if (start_evt) begin
        active <= shadow;
        cont_q <= bus.continuous;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PH_IDLE;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    start_evt = 1'b0;
    if (!bus.enable) begin
      state_nxt = PH_IDLE;
      row_nxt   = '0;
    end else begin
      case (state)
        PH_IDLE: if (bus.frame_start) begin
          state_nxt = PH_INIT;
          row_nxt   = '0;
          start_evt = 1'b1;
        end
        PH_INIT: if (expire) state_nxt = PH_PROG;
        PH_PROG: if (expire) begin
          if (row == RW'(ROWS - 1)) begin
            state_nxt = PH_EMIT;
            row_nxt   = '0;
          end else begin
            state_nxt = PH_INIT;
            row_nxt   = row + RW'(1);
          end
        end
        PH_EMIT:  if (expire) state_nxt = PH_COMP2;
        PH_COMP2: if (expire) state_nxt = PH_TAIL;
        PH_TAIL: if (expire) begin
          if (cont_q) begin
            state_nxt = PH_INIT;
            row_nxt   = '0;
            start_evt = 1'b1;
          end else begin
            state_nxt = PH_IDLE;
          end
        end
        default: state_nxt = PH_IDLE;
      endcase
    end
  end

  // Every transition lands in a different phase, so a phase change is exactly a timer reload.
  assign tmr_load = (state_nxt != state) && (state_nxt != PH_IDLE);
  assign tmr_val  = start_evt ? shadow[phase_sel(state_nxt)] : active[phase_sel(state_nxt)];

  amoled_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_comb begin
    row_oh  = ROWS'(1) << row_nxt;
    vinit_d = '0;
    vcomp_d = '0;
    vscan_d = '0;
    vem1_d  = '0;
    vem2_d  = '0;
    case (state_nxt)
      PH_INIT: begin
        vinit_d = row_oh;
        vcomp_d = row_oh;
      end
      PH_PROG: begin
        vcomp_d = row_oh;
        vscan_d = row_oh;
      end
      PH_EMIT: begin
        vem1_d = '1;
        vem2_d = '1;
      end
      PH_COMP2: begin
        vcomp_d = '1;
        vem1_d  = '1;
        vem2_d  = '1;
      end
      PH_TAIL: vem1_d = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.vinit      <= '0;
      bus.vcomp      <= '0;
      bus.vscan      <= '0;
      bus.vem1       <= '0;
      bus.vem2       <= '0;
      bus.busy       <= 1'b0;
      bus.row_idx    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.vinit      <= vinit_d;
      bus.vcomp      <= vcomp_d;
      bus.vscan      <= vscan_d;
      bus.vem1       <= vem1_d;
      bus.vem2       <= vem2_d;
      bus.busy       <= (state_nxt != PH_IDLE);
      bus.row_idx    <= (state_nxt == PH_INIT || state_nxt == PH_PROG) ? row_nxt : '0;
      bus.frame_done <= bus.enable && (state == PH_TAIL) && expire;
    end
  end

endmodule

// File: tb/tb_amoled_row_waveform_seq.sv
// Directed bench for a 2-row sequencer with small reset-default durations (4/3/6/3/2).
// Observed word per cycle: {vinit,vcomp,vscan,vem1,vem2,row_idx,busy,frame_done}.
module tb_amoled_row_waveform_seq;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   viol     = 0;
  bit   armed    = 0;

  amoled_row_waveform_seq_if #(.ROWS(2), .CNT_W(8)) bus ();

  amoled_row_waveform_seq #(
    .ROWS(2), .CNT_W(8), .D_INIT(4), .D_PROG(3), .D_EMIT(6), .D_COMP2(3), .D_TAIL(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return 32'({bus.vinit, bus.vcomp, bus.vscan, bus.vem1, bus.vem2, bus.row_idx, bus.busy, bus.frame_done});
  endfunction

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Expected {vinit,vcomp,vscan,vem1,vem2,row_idx} for cycle t (1-based) of a frame.
  function automatic logic [10:0] exp_out(input int t, input int di, dp, de, dc, dt);
    int s;
    logic [1:0] oh;
    s = t - 1;
    for (int r = 0; r < 2; r++) begin
      oh = 2'b01 << r;
      if (s < eff(di)) return {oh, oh, 2'b00, 2'b00, 2'b00, 1'(r)};
      s -= eff(di);
      if (s < eff(dp)) return {2'b00, oh, oh, 2'b00, 2'b00, 1'(r)};
      s -= eff(dp);
    end
    if (s < eff(de)) return {2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0};
    s -= eff(de);
    if (s < eff(dc)) return {2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 1'b0};
    s -= eff(dc);
    if (s < eff(dt)) return {2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0};
    return '0;
  endfunction

  function automatic logic [31:0] exp_busy(input int t, input int di, dp, de, dc, dt, input logic done);
    return 32'({exp_out(t, di, dp, de, dc, dt), 1'b1, done});
  endfunction

  // Checks cycles 1..L of a frame; returns positioned at cycle L+1.
  task automatic run_frame(input string tag, input int di, dp, de, dc, dt, input logic done_first);
    int len;
    len = 2 * (eff(di) + eff(dp)) + eff(de) + eff(dc) + eff(dt);
    for (int t = 1; t <= len; t++) begin
      check($sformatf("%s_t%0d", tag, t), obs(), exp_busy(t, di, dp, de, dc, dt, (t == 1) ? done_first : 1'b0));
      tick();
    end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [7:0] data);
    bus.cfg_wr = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_data = data;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (armed && !reset) begin
      if ((bus.vscan & bus.vem1) != 2'b00) viol++;
      if (!$onehot0(bus.vinit | bus.vscan)) viol++;
      if ($isunknown({bus.vinit, bus.vcomp, bus.vscan, bus.vem1, bus.vem2,
                      bus.busy, bus.row_idx, bus.frame_done})) viol++;
    end
  end

  initial begin
    logic done_seen;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.continuous = 1'b0;
    bus.frame_start = 1'b0;
    bus.cfg_wr = 1'b0;
    bus.cfg_sel = 3'd0;
    bus.cfg_data = 8'd0;
    tick();
    tick();
    check("reset_state", obs(), 32'h0);
    reset = 1'b0;
    armed = 1'b1;
    bus.enable = 1'b1;
    tick();
    check("idle_after_reset", obs(), 32'h0);

    // Single frame, programmed 2/3/5/3/2 -> 20 cycles, frame_done in cycle 21.
    cfg_write(3'd0, 8'd2);
    cfg_write(3'd1, 8'd3);
    cfg_write(3'd2, 8'd5);
    cfg_write(3'd3, 8'd3);
    cfg_write(3'd4, 8'd2);
    start_frame();
    run_frame("T1", 2, 3, 5, 3, 2, 1'b0);
    check("T1_done", obs(), 32'h1);
    tick();
    check("T1_idle", obs(), 32'h0);

    // Continuous: back-to-back frames, frame_done on cycle 1 of each following frame.
    bus.continuous = 1'b1;
    start_frame();
    run_frame("C0", 2, 3, 5, 3, 2, 1'b0);
    run_frame("C1", 2, 3, 5, 3, 2, 1'b1);
    run_frame("C2", 2, 3, 5, 3, 2, 1'b1);
    check("C3_start", obs(), exp_busy(1, 2, 3, 5, 3, 2, 1'b1));
    bus.continuous = 1'b0;
    bus.enable = 1'b0;
    tick();
    check("C_stop", obs(), 32'h0);
    bus.enable = 1'b1;

    // Same-cycle write is not used; mid-frame write lands next frame; sel=6 ignored.
    bus.cfg_wr = 1'b1;
    bus.cfg_sel = 3'd2;
    bus.cfg_data = 8'd9;
    start_frame();
    bus.cfg_wr = 1'b0;
    fork
      run_frame("A", 2, 3, 5, 3, 2, 1'b0);
      begin
        repeat (4) tick();
        cfg_write(3'd2, 8'd8);
        cfg_write(3'd6, 8'd1);
      end
    join
    check("A_done", obs(), 32'h1);
    tick();
    start_frame();
    run_frame("B", 2, 3, 8, 3, 2, 1'b0);
    check("B_done", obs(), 32'h1);
    tick();

    // frame_start while busy ignored; enable drop in PROG(1) aborts without frame_done.
    start_frame();
    tick();
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("busy_fs_ignored", obs(), exp_busy(4, 2, 3, 8, 3, 2, 1'b0));
    repeat (4) tick();
    check("prog1", obs(), exp_busy(8, 2, 3, 8, 3, 2, 1'b0));
    bus.enable = 1'b0;
    tick();
    check("abort", obs(), 32'h0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("fs_disabled", obs(), 32'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      done_seen = done_seen | bus.frame_done;
    end
    check("no_done_after_abort", 32'(done_seen), 32'h0);
    bus.enable = 1'b1;

    // INIT programmed to 0 behaves as 1 cycle.
    cfg_write(3'd0, 8'd0);
    start_frame();
    run_frame("Z", 0, 3, 8, 3, 2, 1'b0);
    check("Z_done", obs(), 32'h1);
    tick();

    // Reset mid-EMIT clears drives and restores the 4/3/6/3/2 defaults.
    start_frame();
    repeat (9) tick();
    check("emit_pre_reset", obs(), exp_busy(10, 0, 3, 8, 3, 2, 1'b0));
    reset = 1'b1;
    tick();
    check("reset_mid_emit", obs(), 32'h0);
    reset = 1'b0;
    tick();
    start_frame();
    run_frame("D", 4, 3, 6, 3, 2, 1'b0);
    check("D_done", obs(), 32'h1);
    tick();

    check("invariants", 32'(viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
